// File: rtl/anita3_scaler_pkg.sv
// Shared definitions for the ANITA-3 scaler snapshot controller: FSM encoding,
// channel/address widths and the read-request payload.
package anita3_scaler_pkg;

  localparam int unsigned CH_W   = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned SEQ_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SWAP    = 2'd2
  } snap_state_e;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
  } rd_req_t;

endpackage

// File: rtl/anita3_scaler_snapshot_ctrl_if.sv
// Request/acknowledge bundle for the two read ports; master = requester side,
// slave = arbiter side.
interface anita3_scaler_snapshot_ctrl_if;
  logic req_a;
  logic req_b;
  logic ack_a;
  logic ack_b;

  modport master (output req_a, output req_b, input ack_a, input ack_b);
  modport slave  (input req_a, input req_b, output ack_a, output ack_b);
endinterface

// File: rtl/anita3_rr_arb2.sv
// Two-way round-robin arbiter with registered grant (the acknowledge).
// A port is masked while its own ack is high, since it still holds req then.
module anita3_rr_arb2 (
  input  logic                          clk_i,
  input  logic                          rst_i,
  anita3_scaler_snapshot_ctrl_if.slave  bus,
  output logic                          gnt_a_c,
  output logic                          gnt_b_c
);

  logic ack_a_q;
  logic ack_b_q;
  logic prio_b_q;
  logic req_a_m;
  logic req_b_m;

  always_comb begin
    req_a_m = bus.req_a & ~ack_a_q;
    req_b_m = bus.req_b & ~ack_b_q;
    gnt_a_c = req_a_m & (~req_b_m | ~prio_b_q);
    gnt_b_c = req_b_m & (~req_a_m |  prio_b_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      prio_b_q <= 1'b0;
    end else begin
      ack_a_q <= gnt_a_c;
      ack_b_q <= gnt_b_c;
      if (gnt_a_c) begin
        prio_b_q <= 1'b1;
      end else if (gnt_b_c) begin
        prio_b_q <= 1'b0;
      end
    end
  end

  assign bus.ack_a = ack_a_q;
  assign bus.ack_b = ack_b_q;

endmodule

// File: rtl/anita3_scaler_snapshot_ctrl.sv
// Double-buffered PPS scaler snapshot with two arbitrated read ports.
// Optional XOR checksum at address NCH when SCALER_CHECKSUM_EN is defined.
module anita3_scaler_snapshot_ctrl
  import anita3_scaler_pkg::*;
#(
  parameter int unsigned NCH = 8
) (
  input  logic                  clk33_i,
  input  logic                  rst_i,
  input  logic                  pps_clk33_i,
  input  logic [CH_W*NCH-1:0]   scaler_i,
  input  logic                  ra_req_i,
  input  logic                  rb_req_i,
  input  logic [ADDR_W-1:0]     ra_addr_i,
  input  logic [ADDR_W-1:0]     rb_addr_i,
  output logic                  ra_ack_o,
  output logic                  rb_ack_o,
  output logic [CH_W-1:0]       rd_data_o,
  output logic                  busy_o,
  output logic [SEQ_W-1:0]      snap_seq_o,
  output logic                  overrun_o
);

  snap_state_e          state_q;
  logic [ADDR_W-1:0]    idx_q;
  logic                 busy_q;
  logic                 ovr_q;
  logic                 act_q;
  logic [SEQ_W-1:0]     seq_q;
  logic [CH_W-1:0]      bank_q [2][NCH];
  logic [CH_W-1:0]      rd_data_q;
`ifdef SCALER_CHECKSUM_EN
  logic [CH_W-1:0]      csum_q [2];
`endif

  logic                 shd_c;
  logic [CH_W-1:0]      cap_ch_c;
  logic                 gnt_a_c;
  logic                 gnt_b_c;
  rd_req_t              rd_req_c;
  logic [CH_W-1:0]      rd_word_c;

  anita3_scaler_snapshot_ctrl_if arb_if ();

  assign arb_if.req_a = ra_req_i;
  assign arb_if.req_b = rb_req_i;

  anita3_rr_arb2 u_arb (
    .clk_i   (clk33_i),
    .rst_i   (rst_i),
    .bus     (arb_if),
    .gnt_a_c (gnt_a_c),
    .gnt_b_c (gnt_b_c)
  );

  assign shd_c = ~act_q;

  // Channel selected by the capture index.
  always_comb begin
    cap_ch_c = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx_q == ADDR_W'(k)) begin
        cap_ch_c = scaler_i[CH_W*k +: CH_W];
      end
    end
  end

  // Read lookup against the bank active in the grant cycle.
  always_comb begin
    rd_req_c.vld  = gnt_a_c | gnt_b_c;
    rd_req_c.addr = gnt_b_c ? rb_addr_i : ra_addr_i;
    rd_word_c     = '0;
    for (int k = 0; k < NCH; k++) begin
      if (rd_req_c.addr == ADDR_W'(k)) begin
        rd_word_c = bank_q[act_q][k];
      end
    end
`ifdef SCALER_CHECKSUM_EN
    if (rd_req_c.addr == ADDR_W'(NCH)) begin
      rd_word_c = csum_q[act_q];
    end
`endif
  end

  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_req_c.vld) begin
      rd_data_q <= rd_word_c;
    end
  end

  // Snapshot FSM; the shadow bank is filled one channel per cycle, then swapped.
  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      act_q   <= 1'b0;
      seq_q   <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < NCH; k++) begin
          bank_q[b][k] <= '0;
        end
      end
`ifdef SCALER_CHECKSUM_EN
      csum_q[0] <= '0;
      csum_q[1] <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pps_clk33_i) begin
            state_q <= ST_CAPTURE;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (pps_clk33_i) begin
            ovr_q <= 1'b1;
          end
          for (int k = 0; k < NCH; k++) begin
            if (idx_q == ADDR_W'(k)) begin
              bank_q[shd_c][k] <= cap_ch_c;
            end
          end
`ifdef SCALER_CHECKSUM_EN
          csum_q[shd_c] <= (idx_q == '0) ? cap_ch_c : (csum_q[shd_c] ^ cap_ch_c);
`endif
          if (idx_q == ADDR_W'(NCH - 1)) begin
            state_q <= ST_SWAP;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        ST_SWAP: begin
          if (pps_clk33_i) begin
            ovr_q <= 1'b1;
          end
          act_q   <= ~act_q;
          seq_q   <= seq_q + SEQ_W'(1);
          idx_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ra_ack_o   = arb_if.ack_a;
  assign rb_ack_o   = arb_if.ack_b;
  assign rd_data_o  = rd_data_q;
  assign busy_o     = busy_q;
  assign snap_seq_o = seq_q;
  assign overrun_o  = ovr_q;

endmodule
